// File: rtl/dmem_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dmem_boot_sequencer
// Purpose  : Preloads core data memory while holding the core in reset, then
//            runs it and captures result/done stores. Optional watchdog via
//            the DMEM_BOOT_WATCHDOG_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_boot_sequencer #(
    parameter logic [31:0] RESULT_ADDR    = 32'h0200_0008,
    parameter logic [31:0] DONE_ADDR      = 32'h0200_000C,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_data,
    input  logic             cmd_last,
    output logic             cpu_reset,
    output logic             ext_memwrite,
    output logic [31:0]      ext_dataadr,
    output logic [31:0]      ext_writedata,
    input  logic             MemWrite,
    input  logic [31:0]      DataAdr,
    input  logic [31:0]      WriteData,
    output logic [31:0]      result,
    output logic             result_valid,
    output logic [CNT_W-1:0] result_cnt,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_LOAD    = 3'd1;
    localparam logic [2:0] c_GAP     = 3'd2;
    localparam logic [2:0] c_RELEASE = 3'd3;
    localparam logic [2:0] c_RUN     = 3'd4;
    localparam logic [2:0] c_DONE    = 3'd5;
    localparam logic [2:0] c_TIMEOUT = 3'd6;

    logic [2:0]       r_state;
    logic [2:0]       w_nextState;
    logic             r_lastFlag;
    logic             r_cpuReset;
    logic             r_extMemWrite;
    logic [31:0]      r_extDataAdr;
    logic [31:0]      r_extWriteData;
    logic [31:0]      r_result;
    logic             r_resultValid;
    logic [CNT_W-1:0] r_resultCnt;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;
    logic             w_accept;
    logic             w_storeValid;
    logic             w_resultHit;
    logic             w_doneHit;
    logic             w_wdExpire;

    assign cmd_ready    = (r_state == c_LOAD);
    assign w_accept     = cmd_valid && cmd_ready;
    assign w_storeValid = MemWrite && !r_cpuReset;
    assign w_resultHit  = w_storeValid && (DataAdr == RESULT_ADDR);
    assign w_doneHit    = w_storeValid && (DataAdr == DONE_ADDR) && (WriteData == 32'd1);

`ifdef DMEM_BOOT_WATCHDOG_EN
    logic [31:0] r_wdCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdCnt <= '0;
        end else if (r_state == c_RELEASE) begin
            r_wdCnt <= '0;
        end else if (r_state == c_RUN) begin
            r_wdCnt <= r_wdCnt + 32'd1;
        end
    end

    // Fires on the RUN cycle in which the count reaches the budget.
    assign w_wdExpire = (r_state == c_RUN) && ((r_wdCnt + 32'd1) == TIMEOUT_CYCLES);
`else
    logic w_unusedTimeoutCfg;

    assign w_unusedTimeoutCfg = ^TIMEOUT_CYCLES;
    assign w_wdExpire         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // if-based tests make an unknown store strobe behave as "no write".
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE, c_DONE, c_TIMEOUT: begin
                if (start) w_nextState = c_LOAD;
            end
            c_LOAD: begin
                if (w_accept) w_nextState = c_GAP;
            end
            c_GAP: begin
                w_nextState = r_lastFlag ? c_RELEASE : c_LOAD;
            end
            c_RELEASE: begin
                w_nextState = c_RUN;
            end
            c_RUN: begin
                if (w_doneHit) begin
                    w_nextState = c_DONE;
                end else if (w_wdExpire) begin
                    w_nextState = c_TIMEOUT;
                end
            end
            default: begin
                w_nextState = c_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lastFlag     <= 1'b0;
            r_cpuReset     <= 1'b1;
            r_extMemWrite  <= 1'b0;
            r_extDataAdr   <= '0;
            r_extWriteData <= '0;
            r_result       <= '0;
            r_resultValid  <= 1'b0;
            r_resultCnt    <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_cpuReset     <= (w_nextState != c_RUN);
            r_busy         <= (w_nextState == c_LOAD) || (w_nextState == c_GAP) ||
                              (w_nextState == c_RELEASE) || (w_nextState == c_RUN);
            r_done         <= (w_nextState == c_DONE);
            r_timeout      <= (w_nextState == c_TIMEOUT);
            r_extMemWrite  <= w_accept;
            r_extDataAdr   <= w_accept ? cmd_addr : 32'd0;
            r_extWriteData <= w_accept ? cmd_data : 32'd0;
            r_resultValid  <= 1'b0;
            if (w_accept) begin
                r_lastFlag <= cmd_last;
            end
            if (r_state == c_RELEASE) begin
                r_resultCnt <= '0;
            end else if ((r_state == c_RUN) && w_resultHit) begin
                r_result      <= WriteData;
                r_resultValid <= 1'b1;
                if (r_resultCnt != {CNT_W{1'b1}}) begin
                    r_resultCnt <= r_resultCnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign cpu_reset     = r_cpuReset;
    assign ext_memwrite  = r_extMemWrite;
    assign ext_dataadr   = r_extDataAdr;
    assign ext_writedata = r_extWriteData;
    assign result        = r_result;
    assign result_valid  = r_resultValid;
    assign result_cnt    = r_resultCnt;
    assign busy          = r_busy;
    assign done          = r_done;
    assign timeout       = r_timeout;

endmodule
`default_nettype wire
